// File: rtl/clk_rst_sequencer.sv
// Clock/reset sequencer: waits for a stable PLL lock, releases downstream reset, and handles lock loss and manual resets.
// Optional macro LOSS_CNT_EN adds a saturating 8-bit lock-loss counter on loss_cnt.
module clk_rst_sequencer #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       locked,
    input  logic       SW,
    output logic       rst_out,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RUN       = 3'd2,
        HOLD      = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST   = 8'(HOLD_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic        locked_meta_r;
    logic        locked_s;
    logic        sw_meta_r;
    logic        sw_s;
    logic        sw_prev_r;
    logic        manual_req_s;
    logic [15:0] stab_cnt_r;
    logic [15:0] stab_cnt_nxt_s;
    logic [7:0]  hold_cnt_r;
    logic [7:0]  hold_cnt_nxt_s;
    logic        lock_lost_nxt_s;
    logic        fault_entry_s;
    logic        rst_out_r;
    logic        ready_r;
    logic        lock_lost_r;

    // Two-flop synchronizers for the asynchronous inputs plus the SW edge-detect flop
    always_ff @(posedge CLK) begin
        if (RST) begin
            locked_meta_r <= 1'b0;
            locked_s      <= 1'b0;
            sw_meta_r     <= 1'b0;
            sw_s          <= 1'b0;
            sw_prev_r     <= 1'b0;
        end else begin
            locked_meta_r <= locked;
            locked_s      <= locked_meta_r;
            sw_meta_r     <= SW;
            sw_s          <= sw_meta_r;
            sw_prev_r     <= sw_s;
        end
    end

    // A held-high SW yields a single request on its synchronized rising edge
    assign manual_req_s = sw_s & ~sw_prev_r;

    // Next-state, counter and sticky-flag logic
    always_comb begin
        state_nxt_s     = state_r;
        stab_cnt_nxt_s  = stab_cnt_r;
        hold_cnt_nxt_s  = hold_cnt_r;
        lock_lost_nxt_s = lock_lost_r;
        fault_entry_s   = 1'b0;
        case (state_r)
            WAIT_LOCK: begin
                stab_cnt_nxt_s = 16'd0;
                if (locked_s) begin
                    state_nxt_s = STABLE;
                end else begin
                    state_nxt_s = WAIT_LOCK;
                end
            end
            STABLE: begin
                // Any dropout restarts the full stability window
                if (!locked_s) begin
                    state_nxt_s    = WAIT_LOCK;
                    stab_cnt_nxt_s = 16'd0;
                end else if (stab_cnt_r == STABLE_LAST) begin
                    state_nxt_s    = RUN;
                    stab_cnt_nxt_s = 16'd0;
                end else begin
                    stab_cnt_nxt_s = stab_cnt_r + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_nxt_s     = FAULT;
                    fault_entry_s   = 1'b1;
                    lock_lost_nxt_s = 1'b1;
                end else if (manual_req_s) begin
                    state_nxt_s     = HOLD;
                    hold_cnt_nxt_s  = 8'd0;
                    lock_lost_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_nxt_s     = FAULT;
                    fault_entry_s   = 1'b1;
                    lock_lost_nxt_s = 1'b1;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    state_nxt_s    = RUN;
                    hold_cnt_nxt_s = 8'd0;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                end
            end
            FAULT: begin
                state_nxt_s = WAIT_LOCK;
            end
            default: begin
                state_nxt_s    = WAIT_LOCK;
                stab_cnt_nxt_s = 16'd0;
                hold_cnt_nxt_s = 8'd0;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they move with the state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= WAIT_LOCK;
            stab_cnt_r  <= 16'd0;
            hold_cnt_r  <= 8'd0;
            rst_out_r   <= 1'b1;
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            stab_cnt_r  <= stab_cnt_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            rst_out_r   <= (state_nxt_s != RUN);
            ready_r     <= (state_nxt_s == RUN);
            lock_lost_r <= lock_lost_nxt_s;
        end
    end

    assign rst_out   = rst_out_r;
    assign ready     = ready_r;
    assign lock_lost = lock_lost_r;

`ifdef LOSS_CNT_EN
    logic [7:0] loss_cnt_r;

    // Saturating count of FAULT entries
    always_ff @(posedge CLK) begin
        if (RST) begin
            loss_cnt_r <= 8'd0;
        end else if (fault_entry_s && (loss_cnt_r != 8'hFF)) begin
            loss_cnt_r <= loss_cnt_r + 8'd1;
        end else begin
            loss_cnt_r <= loss_cnt_r;
        end
    end

    assign loss_cnt = loss_cnt_r;
`else
    logic unused_fault_entry_s;
    assign unused_fault_entry_s = fault_entry_s;
    assign loss_cnt             = 8'h00;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed self-checking bench for clk_rst_sequencer with STABLE_CYCLES=8, HOLD_CYCLES=4.
// Expected loss_cnt values follow LOSS_CNT_EN when it is defined for the build.
module tb_clk_rst_sequencer;

    logic       CLK;
    logic       RST;
    logic       locked;
    logic       SW;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_cnt;

    int total = 0;
    int bad   = 0;

`ifdef LOSS_CNT_EN
    localparam bit LCE = 1'b1;
`else
    localparam bit LCE = 1'b0;
`endif

    clk_rst_sequencer #(
        .STABLE_CYCLES(8),
        .HOLD_CYCLES  (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .locked   (locked),
        .SW       (SW),
        .rst_out  (rst_out),
        .ready    (ready),
        .lock_lost(lock_lost),
        .loss_cnt (loss_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_loss(input int n);
        if (!LCE) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    initial begin
        RST    = 1'b1;
        locked = 1'b0;
        SW     = 1'b0;

        // Reset state
        step(2);
        chk("rst_rst_out", 8'(rst_out), 8'd1);
        chk("rst_ready", 8'(ready), 8'd0);
        chk("rst_lock_lost", 8'(lock_lost), 8'd0);
        chk("rst_loss_cnt", loss_cnt, 8'd0);

        // Release reset, idle, then lock: ready on edge 11
        @(negedge CLK); RST = 1'b0;
        step(2);
        chk("idle_rst_out", 8'(rst_out), 8'd1);
        @(negedge CLK); locked = 1'b1;
        step(10);
        chk("lock_edge10_ready", 8'(ready), 8'd0);
        chk("lock_edge10_rst_out", 8'(rst_out), 8'd1);
        step(1);
        chk("lock_edge11_ready", 8'(ready), 8'd1);
        chk("lock_edge11_rst_out", 8'(rst_out), 8'd0);

        // Lock drop in RUN: ready falls on edge 3, FAULT then WAIT_LOCK
        @(negedge CLK); locked = 1'b0;
        step(2);
        chk("drop_edge2_ready", 8'(ready), 8'd1);
        step(1);
        chk("drop_edge3_ready", 8'(ready), 8'd0);
        chk("drop_edge3_rst_out", 8'(rst_out), 8'd1);
        chk("drop_lock_lost", 8'(lock_lost), 8'd1);
        chk("drop_loss_cnt", loss_cnt, exp_loss(1));
        step(1);
        chk("drop_wait_rst_out", 8'(rst_out), 8'd1);

        // Relock with a one-cycle glitch: count restarts from the second rise
        @(negedge CLK); locked = 1'b1;
        step(5);
        @(negedge CLK); locked = 1'b0;
        step(1);
        @(negedge CLK); locked = 1'b1;
        step(10);
        chk("glitch_edge10_ready", 8'(ready), 8'd0);
        step(1);
        chk("glitch_edge11_ready", 8'(ready), 8'd1);
        chk("glitch_lock_lost_sticky", 8'(lock_lost), 8'd1);

        // Manual request: SW high for 10 cycles gives one 4-cycle reset pulse
        @(negedge CLK); SW = 1'b1;
        step(2);
        chk("sw_edge2_rst_out", 8'(rst_out), 8'd0);
        step(1);
        chk("hold_first_rst_out", 8'(rst_out), 8'd1);
        chk("hold_first_ready", 8'(ready), 8'd0);
        chk("hold_lock_lost_clr", 8'(lock_lost), 8'd0);
        step(3);
        chk("hold_last_rst_out", 8'(rst_out), 8'd1);
        step(1);
        chk("hold_done_rst_out", 8'(rst_out), 8'd0);
        chk("hold_done_ready", 8'(ready), 8'd1);
        step(3);
        chk("sw_held_no_retrig", 8'(rst_out), 8'd0);
        @(negedge CLK); SW = 1'b0;
        step(5);
        chk("sw_release_ready", 8'(ready), 8'd1);

        // Simultaneous SW rise and lock drop: FAULT wins
        @(negedge CLK); SW = 1'b1; locked = 1'b0;
        step(2);
        chk("simul_edge2_ready", 8'(ready), 8'd1);
        step(1);
        chk("simul_edge3_ready", 8'(ready), 8'd0);
        chk("simul_lock_lost", 8'(lock_lost), 8'd1);
        chk("simul_loss_cnt", loss_cnt, exp_loss(2));
        @(negedge CLK); SW = 1'b0;

        // Relock, enter HOLD, then RST mid-HOLD
        @(negedge CLK); locked = 1'b1;
        step(11);
        chk("relock_ready", 8'(ready), 8'd1);
        @(negedge CLK); SW = 1'b1;
        step(4);
        chk("midhold_rst_out", 8'(rst_out), 8'd1);
        @(negedge CLK); RST = 1'b1;
        step(1);
        chk("rsthold_rst_out", 8'(rst_out), 8'd1);
        chk("rsthold_ready", 8'(ready), 8'd0);
        chk("rsthold_lock_lost", 8'(lock_lost), 8'd0);
        chk("rsthold_loss_cnt", loss_cnt, 8'd0);
        @(negedge CLK); RST = 1'b0; SW = 1'b0;
        step(10);
        chk("restart_edge10_ready", 8'(ready), 8'd0);
        step(1);
        chk("restart_edge11_ready", 8'(ready), 8'd1);

        // 300 forced losses: counter saturates
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK); locked = 1'b0;
            step(4);
            @(negedge CLK); locked = 1'b1;
            step(11);
        end
        chk("sat_ready", 8'(ready), 8'd1);
        chk("sat_lock_lost", 8'(lock_lost), 8'd1);
        chk("sat_loss_cnt", loss_cnt, exp_loss(300));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_rst_sequencer.md
CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

Interface
REQ-001 SHALL have parameter: STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before reset release (legal 2..65535).
REQ-002 SHALL have parameter: HOLD_CYCLES, 16, reset pulse length on manual request (legal 1..255).
REQ-003 SHALL have one clock and a synchronous active-high reset: CLK input, RST input.
REQ-004 SHALL have ports in this order:
 - CLK  input  1  reference clock; all logic on rising edge
 - RST  input  1  synchronous active-high reset
 - locked  input  1  asynchronous PLL/MMCM lock status
 - SW  input  1  asynchronous manual reset request, active high
 - rst_out  output  1  synchronous active-high reset for downstream logic
 - ready  output  1  clocks stable, downstream released
 - lock_lost  output  1  sticky flag: lock dropped while in RUN or HOLD
 - loss_cnt  output  8  saturating lock-loss count (LOSS_CNT_EN only)

Function
REQ-005 SHALL pass locked and SW through separate 2-flop synchronizers (locked_s, sw_s) before any use.
REQ-006 SHALL detect a manual request as a sw_s 0->1 transition; a held-high SW generates exactly one request.
REQ-007 SHALL implement a one-hot or encoded FSM with states WAIT_LOCK, STABLE, RUN, HOLD, FAULT.
REQ-008 WAIT_LOCK: rst_out=1, ready=0; locked_s=1 -> STABLE with stability counter cleared to 0.
REQ-009 STABLE: counter increments per cycle while locked_s=1; locked_s=0 -> WAIT_LOCK, counter cleared; counter==STABLE_CYCLES-1 with locked_s=1 -> RUN.
REQ-010 RUN: rst_out=0, ready=1; locked_s=0 -> FAULT (takes priority over simultaneous manual request); manual request -> HOLD with hold counter cleared.
REQ-011 HOLD: rst_out=1, ready=0 for exactly HOLD_CYCLES cycles, then -> RUN; locked_s=0 at any HOLD cycle -> FAULT; manual requests during HOLD ignored.
REQ-012 FAULT: rst_out=1, ready=0 for exactly one cycle, then -> WAIT_LOCK unconditionally.
REQ-013 rst_out and ready SHALL be registered and change in the same cycle the state register changes; never both 1 or both 0.
REQ-014 Latency: locked 0->1 sampled at edge k, held stable, -> ready=1 after exactly STABLE_CYCLES+3 edges.
REQ-015 Lock-drop latency: locked 1->0 at edge k in RUN -> ready=0, rst_out=1 after exactly 3 edges.
REQ-016 lock_lost SHALL set on entry to FAULT and clear only on RST or on a manual request made in RUN.
REQ-017 Any glitch of locked_s to 0 in STABLE SHALL restart the full STABLE_CYCLES count.

Reset
REQ-018 RST=1 at a rising edge SHALL force WAIT_LOCK, rst_out=1, ready=0, lock_lost=0, loss_cnt=0, all counters and synchronizer/edge flops 0.
REQ-019 RST asserted mid-STABLE, mid-HOLD or in RUN SHALL abort immediately; sequencing restarts from WAIT_LOCK after RST deasserts.
REQ-020 rst_out SHALL be 1 from the first reset edge; no output SHALL be X after one RST cycle.

Configuration
REQ-021 Macro LOSS_CNT_EN defined: loss_cnt increments by 1 on each FAULT entry, saturates at 255, cleared only by RST.
REQ-022 LOSS_CNT_EN undefined: counter logic absent, loss_cnt tied to 8'h00; all other behaviour identical.

Verification
REQ-023 STABLE_CYCLES=8: RST then locked=1 held -> ready=1, rst_out=0 exactly 11 edges after locked first sampled high.
REQ-024 STABLE_CYCLES=8: locked high 5 cycles, low 1 cycle, high again -> ready stays 0 until 11 edges after the second rise.
REQ-025 In RUN, drop locked -> ready=0 three edges later, FAULT one cycle, lock_lost=1, loss_cnt=1 (LOSS_CNT_EN), re-lock -> RUN after STABLE_CYCLES+3 edges.
REQ-026 HOLD_CYCLES=4: in RUN pulse SW high 10 cycles -> rst_out=1 for exactly 4 cycles once, lock_lost cleared, ready=1 after.
REQ-027 Simultaneous SW rise and locked drop in RUN -> FAULT path taken, no HOLD; 300 forced losses -> loss_cnt=255.
REQ-028 Assert RST mid-HOLD -> next edge rst_out=1, ready=0, lock_lost=0, loss_cnt=0, state WAIT_LOCK.
